// File: rtl/antitheft_timer_if.sv
// Handshake bundle between the anti-theft control FSM (master) and the
// time-base/countdown stage (slave).
interface antitheft_timer_if;
    logic       start_timer;
    logic [1:0] interval;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       expired;
    logic       one_hz_enable;

    modport master (
        output start_timer, interval, reprogram, time_param_sel, time_value,
        input  expired, one_hz_enable
    );

    modport slave (
        input  start_timer, interval, reprogram, time_param_sel, time_value,
        output expired, one_hz_enable
    );
endinterface

// File: rtl/antitheft_timer.sv
// 1 Hz time base, four programmable second-parameters and a countdown FSM.
// Define ANTITHEFT_TIMER_DEBUG_EN to add the time_left / timer_busy outputs.
module antitheft_timer #(
    parameter int unsigned CLK_FREQ          = 100000000,
    parameter int unsigned T_ARM_DELAY       = 6,
    parameter int unsigned T_DRIVER_DELAY    = 8,
    parameter int unsigned T_PASSENGER_DELAY = 15,
    parameter int unsigned T_ALARM_ON        = 10
) (
    input  logic               clock,
    input  logic               reset,
    antitheft_timer_if.slave   bus
`ifdef ANTITHEFT_TIMER_DEBUG_EN
    ,
    output logic [3:0]         time_left,
    output logic               timer_busy
`endif
);

    localparam int unsigned DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_FREQ - 1);

    typedef enum logic [1:0] {IDLE, RUNNING, DONE} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] divider;
    logic [3:0]       count, count_n;
    logic [3:0]       params [4];
    logic             expired_q, expired_n;
    logic             start_q;
    logic [1:0]       interval_q;
    logic             tick;
    logic             load;

    assign tick = (divider == DIV_MAX);
    assign load = bus.start_timer && (!start_q || (bus.interval != interval_q));

    // State register plus the datapath registers that follow it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            expired_q  <= 1'b0;
            divider    <= '0;
            start_q    <= 1'b0;
            interval_q <= '0;
            params[0]  <= 4'(T_ARM_DELAY);
            params[1]  <= 4'(T_DRIVER_DELAY);
            params[2]  <= 4'(T_PASSENGER_DELAY);
            params[3]  <= 4'(T_ALARM_ON);
        end else begin
            state      <= state_n;
            count      <= count_n;
            expired_q  <= expired_n;
            start_q    <= bus.start_timer;
            interval_q <= bus.interval;
            if (load || tick)
                divider <= '0;
            else
                divider <= divider + DIV_W'(1);
            // Load samples params before this write lands, so a same-cycle
            // reprogram of the loaded index still counts the old value.
            if (bus.reprogram)
                params[bus.time_param_sel] <= bus.time_value;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        expired_n = expired_q;
        if (!bus.start_timer) begin
            state_n   = IDLE;
            count_n   = '0;
            expired_n = 1'b0;
        end else if (load) begin
            count_n   = params[bus.interval];
            expired_n = 1'b0;
            state_n   = (params[bus.interval] == 4'd0) ? DONE : RUNNING;
        end else begin
            case (state)
                IDLE: expired_n = 1'b0;
                RUNNING: begin
                    if (tick) begin
                        count_n = count - 4'd1;
                        if (count == 4'd1) begin
                            state_n   = DONE;
                            expired_n = 1'b1;
                        end
                    end
                end
                DONE: begin
                    expired_n = 1'b1;
                    count_n   = '0;
                end
                default: begin
                    state_n   = IDLE;
                    count_n   = '0;
                    expired_n = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.one_hz_enable = tick;
        bus.expired       = expired_q;
`ifdef ANTITHEFT_TIMER_DEBUG_EN
        time_left  = (state == RUNNING) ? count : 4'd0;
        timer_busy = (state == RUNNING);
`endif
    end

endmodule

// File: tb/tb_antitheft_timer.sv
// Randomized and directed bench for antitheft_timer against an event-timing
// reference model (load age vs. loaded seconds, divider age modulo period).
module tb_antitheft_timer;
    localparam int unsigned CLK = 10;

    logic clock = 1'b0;
    logic reset;

    antitheft_timer_if bus ();

    antitheft_timer #(.CLK_FREQ(CLK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int unsigned m_params [4];
    bit          m_active;
    int unsigned m_load_val;
    int unsigned m_load_age;
    int unsigned m_div_age;
    bit          m_prev_start;
    logic [1:0]  m_prev_int;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit exp_expired();
        if (!m_active) return 1'b0;
        if (m_load_val == 0) return (m_load_age >= 1);
        return (m_load_age >= m_load_val * CLK);
    endfunction

    function automatic bit exp_one_hz();
        return ((m_div_age % CLK) == CLK - 1);
    endfunction

    task automatic model_reset();
        m_params[0] = 6; m_params[1] = 8; m_params[2] = 15; m_params[3] = 10;
        m_active = 0; m_load_val = 0; m_load_age = 0; m_div_age = 0;
        m_prev_start = 0; m_prev_int = 2'b00;
    endtask

    // One clock edge: update model from the inputs the DUT sampled, then
    // compare at the following falling edge.
    task automatic step();
        bit ld;
        @(posedge clock);
        ld = bus.start_timer && (!m_prev_start || (bus.interval != m_prev_int));
        if (ld) begin
            m_load_val = m_params[bus.interval];
            m_load_age = 0;
            m_active   = 1;
            m_div_age  = 0;
        end else begin
            m_div_age++;
            if (m_active) m_load_age++;
        end
        if (!bus.start_timer) m_active = 0;
        if (bus.reprogram) m_params[bus.time_param_sel] = bus.time_value;
        m_prev_start = bus.start_timer;
        m_prev_int   = bus.interval;
        @(negedge clock);
        check_val("expired", bus.expired, exp_expired());
        check_val("one_hz", bus.one_hz_enable, exp_one_hz());
    endtask

    task automatic idle_inputs();
        bus.start_timer    = 1'b0;
        bus.interval       = 2'b00;
        bus.reprogram      = 1'b0;
        bus.time_param_sel = 2'b00;
        bus.time_value     = 4'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        #1;
        model_reset();
        check_val("rst_expired", bus.expired, 1'b0);
        check_val("rst_one_hz", bus.one_hz_enable, 1'b0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Steps until expired is seen; n = edges after the load edge.
    task automatic wait_expired(input int unsigned budget, output int unsigned n);
        n = 0;
        while (!bus.expired && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic start_load(input logic [1:0] iv);
        bus.start_timer = 1'b0;
        step();
        bus.start_timer = 1'b1;
        bus.interval    = iv;
        step();
    endtask

    task automatic reprogram_param(input logic [1:0] sel, input logic [3:0] val);
        bus.reprogram      = 1'b1;
        bus.time_param_sel = sel;
        bus.time_value     = val;
        step();
        bus.reprogram = 1'b0;
    endtask

    initial begin
        int unsigned n;
        int unsigned want [4];
        want[0] = 60; want[1] = 80; want[2] = 150; want[3] = 100;

        do_reset();

        // First divider pulse and pulse spacing
        n = 0;
        while (!bus.one_hz_enable && n < 50) begin step(); n++; end
        check_val("first_pulse_edges", n, CLK - 1);
        n = 0;
        do begin step(); n++; end while (!bus.one_hz_enable && n < 50);
        check_val("pulse_period", n, CLK);

        // Reset parameter values seen through load latency
        for (int i = 0; i < 4; i++) begin
            start_load(2'(i));
            wait_expired(400, n);
            check_val($sformatf("param%0d_latency", i), n, want[i]);
        end

        // Expired holds while requested, drops one edge after release
        repeat (5) step();
        check_val("expired_hold", bus.expired, 1'b1);
        bus.start_timer = 1'b0;
        step();
        check_val("expired_drop", bus.expired, 1'b0);

        // Interval change mid-count reloads
        start_load(2'b10);
        repeat (49) step();
        bus.interval = 2'b11;
        step();
        check_val("reload_drop", bus.expired, 1'b0);
        wait_expired(400, n);
        check_val("reload_latency", n, 100);

        // Reprogram arm delay to 3, then to 0
        bus.start_timer = 1'b0;
        step();
        reprogram_param(2'b00, 4'd3);
        start_load(2'b00);
        wait_expired(400, n);
        check_val("arm3_latency", n, 30);
        bus.start_timer = 1'b0;
        step();
        reprogram_param(2'b00, 4'd0);
        start_load(2'b00);
        check_val("arm0_load_edge", bus.expired, 1'b0);
        wait_expired(10, n);
        check_val("arm0_latency", n, 1);

        // Reprogram during a running driver count
        start_load(2'b01);
        repeat (19) step();
        reprogram_param(2'b01, 4'd2);
        wait_expired(400, n);
        check_val("driver_keep_latency", n, 60);
        start_load(2'b01);
        wait_expired(400, n);
        check_val("driver_new_latency", n, 20);

        // Same-cycle reprogram and load of the same index uses old value
        bus.start_timer = 1'b0;
        step();
        bus.start_timer    = 1'b1;
        bus.interval       = 2'b11;
        bus.reprogram      = 1'b1;
        bus.time_param_sel = 2'b11;
        bus.time_value     = 4'd1;
        step();
        bus.reprogram = 1'b0;
        wait_expired(400, n);
        check_val("same_cycle_old", n, 100);

        // Asynchronous reset mid-count
        start_load(2'b01);
        repeat (35) step();
        #2;
        do_reset();
        repeat (50) step();
        check_val("post_reset_idle", bus.expired, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 39) == 0) bus.start_timer = ~bus.start_timer;
            if ($urandom_range(0, 59) == 0) bus.interval = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) begin
                bus.reprogram      = 1'b1;
                bus.time_param_sel = 2'($urandom_range(0, 3));
                bus.time_value     = 4'($urandom_range(0, 6));
            end else begin
                bus.reprogram = 1'b0;
            end
            if ($urandom_range(0, 1499) == 0) begin
                #2;
                do_reset();
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #10ms;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
